conv_window_engine: RTL and testbench
=====================================

# conv_window_engine

Streaming 2-D convolution engine that accepts one KERNEL_ROWS-tall pixel column per handshake and keeps the last KERNEL_COLS columns as a sliding window. Each cycle that completes a valid window, it emits one saturated KERNEL_ROWS×KERNEL_COLS multiply-accumulate result. It generalises the single-row PE chain to a full kernel, adding row-position tracking, valid/ready flow control and a channel-cascade partial-sum input. It sits between the line buffer, which supplies columns, and the output-channel accumulator.

## Interface
- KERNEL_ROWS, 5, kernel height (pixels per input column)
- KERNEL_COLS, 5, kernel width (columns held in the window)
- IMG_WIDTH, 32, columns per image row; must be ≥ KERNEL_COLS
- WEIGHT_BW, 8, signed weight width
- DATA_BW, 8, signed pixel width
- SUM_BW, 16, signed output and i_psum width
- ADDR_BW, 5, weight address width; 2^ADDR_BW must be ≥ KERNEL_ROWS*KERNEL_COLS
- BASE_ADDR, 0, first weight address owned by this instance
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- i_w_en  in  1  weight write strobe
- i_addr  in  ADDR_BW  weight address
- i_w  in  WEIGHT_BW  signed weight data
- i_valid  in  1  input column valid
- o_ready  out  1  engine can accept a column
- i_sor  in  1  start of row, qualified by i_valid; the column is treated as column 0
- i_x  in  KERNEL_ROWS*DATA_BW  signed pixel column; row r is at bits [r*DATA_BW +: DATA_BW], and row 0 is the top row
- i_psum  in  SUM_BW  signed cascade partial sum, sampled together with the window-completing column
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result
- o_psum  out  SUM_BW  signed saturated result

## Operation
- **Weight load:** weight index k = i_addr − BASE_ADDR, with k = r*KERNEL_COLS + c.
  - On i_w_en with 0 ≤ k < KERNEL_ROWS*KERNEL_COLS, weight[r][c] is written. Any other address is ignored.
  - A write is visible to windows accepted in the cycle after the write.
- **Accept:** a column is accepted when i_valid && o_ready. o_ready = !o_valid || i_ready, which gives a single-stage output with pass-through on drain.
- **Window:** the window is the KERNEL_COLS−1 stored columns plus the column being accepted. Window column KERNEL_COLS−1 is the newest. On accept, the stored columns shift by one.
- **Column counter col_cnt (0..IMG_WIDTH−1):**
  - Increments on accept.
  - Wraps to 0 after IMG_WIDTH−1.
  - An accept with i_sor forces this column to index 0, and the next value is 1.
- **Window complete:** an accepted column with index ≥ KERNEL_COLS−1. Only complete windows load the output register. Columns with index below KERNEL_COLS−1 only fill the window and produce no output.
- **Arithmetic:**
  - Products are full width, DATA_BW+WEIGHT_BW bits.
  - Products are summed per row, then across rows, plus sign-extended i_psum, in an internal accumulator of ACC_BW = DATA_BW+WEIGHT_BW+clog2(KERNEL_ROWS*KERNEL_COLS)+1 bits. The accumulator never overflows.
  - The result is saturated to SUM_BW: above 2^(SUM_BW−1)−1 clamps to the maximum, below −2^(SUM_BW−1) clamps to the minimum.
- **Reset (rst_n low, asynchronous):**
  - o_valid=0 and o_psum=0.
  - All weights, stored columns and col_cnt reset to 0.
  - o_ready=1 immediately.
  - Reset mid-row discards the partial window and any pending result.

## Timing
- Latency is 1 cycle: a window-completing column accepted at edge t gives o_valid=1 and o_psum valid after edge t.
- o_valid holds, with o_psum stable, until i_ready is high. Both are cleared at the edge where i_ready=1 and no new complete window is accepted.
- Simultaneous drain and new completing accept: o_psum is replaced and o_valid stays 1. This gives full throughput of 1 result per cycle.
- i_valid while o_ready=0: nothing changes, including col_cnt and the window.
- i_w_en together with an accept: the accept uses the old weight.
- o_ready is combinational from o_valid and i_ready. No other combinational input-to-output path exists.

## Configuration
- CONV_WINDOW_RELU_EN defined: ReLU is applied after saturation, so negative results become 0 and the range is 0..2^(SUM_BW−1)−1.
- CONV_WINDOW_RELU_EN not defined: the signed saturated result is output unchanged.

## Structure
- A shared package conv_pkg holds:
  - the clog2 function,
  - the ACC_BW derivation,
  - the saturation bounds helper, which the saturation stage reuses.
- Sub-module conv_window_row: one kernel row. It takes KERNEL_COLS pixels and weights and produces a combinational full-width row sum. It is instantiated KERNEL_ROWS times.
- The top level holds:
  - weight storage and decode,
  - the column shift registers,
  - col_cnt,
  - the handshake,
  - the cross-row adder tree,
  - saturation/ReLU,
  - the output register.

## Test plan
Defaults are 5×5, SUM_BW=16, IMG_WIDTH=32 unless a line says otherwise.
- **All ones:** load all weights=1, i_psum=0, stream 5 columns of all 1s with i_sor on the first → no o_valid after columns 0–3; o_psum=25 one cycle after column 4.
- **Saturation:** all weights=127, pixels=127 → 403225 clamps to o_psum=32767. Weights=−128, pixels=127 → −406400 clamps to o_psum=−32768 (0 with CONV_WINDOW_RELU_EN).
- **Backpressure:** i_ready=0 for 3 cycles after the first result → o_ready=0, o_psum held. Then i_ready=1 → the next stalled column is accepted and results continue 1 per cycle with none lost or duplicated.
- **Row wrap / i_sor:** 32 columns followed by i_sor → exactly 28 results, then 4 silent columns before the next result. An i_sor at column 10 restarts the fill: 4 columns without output.
- **Weight decode:** with BASE_ADDR=25, write addr 25+7=value 3 (r=1, c=2) and addr 24=value 9 (ignored) → impulse pixel at r=1, window col 2 gives o_psum=3. i_psum=−5 shifts the result to −2.
- **Async reset mid-stream:** assert rst_n=0 between edges while o_valid=1 → o_valid=0, o_psum=0, o_ready=1 immediately. After release, the first 4 columns give no output.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared width derivation and saturation bounds for the convolution window engine
package conv_pkg;

    typedef logic signed [63:0] bound_t;

    typedef struct packed {
        bound_t hi;
        bound_t lo;
    } sat_bounds_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // One guard bit on top of the worst-case tap growth keeps the cascade input from overflowing.
    function automatic int acc_bw(input int data_bw, input int weight_bw, input int taps);
        return data_bw + weight_bw + clog2(taps) + 1;
    endfunction

    function automatic sat_bounds_t sat_bounds(input int sum_bw);
        sat_bounds_t b;
        b.hi = (64'sd1 <<< (sum_bw - 1)) - 64'sd1;
        b.lo = -(64'sd1 <<< (sum_bw - 1));
        return b;
    endfunction

endpackage

// File: rtl/conv_window_row.sv
// rtl/conv_window_row.sv - one kernel row: combinational full-width dot product of pixels and weights
module conv_window_row #(
    parameter int KERNEL_COLS = 5,
    parameter int DATA_BW     = 8,
    parameter int WEIGHT_BW   = 8,
    parameter int SUM_BW      = 22
) (
    input  logic [KERNEL_COLS*DATA_BW-1:0]   x,
    input  logic [KERNEL_COLS*WEIGHT_BW-1:0] w,
    output logic [SUM_BW-1:0]                sum
);

    localparam int PROD_BW = DATA_BW + WEIGHT_BW;

    logic signed [PROD_BW-1:0] prod [KERNEL_COLS];
    logic signed [SUM_BW-1:0]  acc;

    for (genvar c = 0; c < KERNEL_COLS; c++) begin : g_tap
        assign prod[c] = $signed(x[c*DATA_BW +: DATA_BW]) * $signed(w[c*WEIGHT_BW +: WEIGHT_BW]);
    end

    always_comb begin
        acc = '0;
        for (int c = 0; c < KERNEL_COLS; c++) begin
            acc = acc + SUM_BW'(prod[c]);
        end
    end

    assign sum = acc;

endmodule

// File: rtl/conv_window_engine.sv
// rtl/conv_window_engine.sv - streaming KxK convolution window with saturated output; CONV_WINDOW_RELU_EN adds ReLU
import conv_pkg::*;

module conv_window_engine #(
    parameter int KERNEL_ROWS = 5,
    parameter int KERNEL_COLS = 5,
    parameter int IMG_WIDTH   = 32,
    parameter int WEIGHT_BW   = 8,
    parameter int DATA_BW     = 8,
    parameter int SUM_BW      = 16,
    parameter int ADDR_BW     = 5,
    parameter int BASE_ADDR   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_w_en,
    input  logic [ADDR_BW-1:0]             i_addr,
    input  logic [WEIGHT_BW-1:0]           i_w,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic                           i_sor,
    input  logic [KERNEL_ROWS*DATA_BW-1:0] i_x,
    input  logic [SUM_BW-1:0]              i_psum,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [SUM_BW-1:0]              o_psum
);

    localparam int TAPS   = KERNEL_ROWS * KERNEL_COLS;
    localparam int ACC_BW = acc_bw(DATA_BW, WEIGHT_BW, TAPS);
    localparam int CNT_BW = (clog2(IMG_WIDTH) > 0) ? clog2(IMG_WIDTH) : 1;
    localparam int COL_BW = KERNEL_ROWS * DATA_BW;
    localparam sat_bounds_t BOUNDS = sat_bounds(SUM_BW);
    localparam bound_t SAT_HI = BOUNDS.hi;
    localparam bound_t SAT_LO = BOUNDS.lo;

    logic [WEIGHT_BW-1:0]       weight [TAPS];
    logic [COL_BW-1:0]          col_q  [KERNEL_COLS-1];
    logic [CNT_BW-1:0]          col_cnt;
    logic [CNT_BW-1:0]          cur_idx;
    logic                       accept;
    logic                       complete;
    logic                       w_hit;
    int                         w_idx;
    logic signed [ACC_BW-1:0]   row_sum [KERNEL_ROWS];
    logic signed [ACC_BW-1:0]   acc;
    logic signed [63:0]         acc_ext;
    logic signed [SUM_BW-1:0]   sat;
    logic signed [SUM_BW-1:0]   result;

    assign o_ready  = !o_valid || i_ready;
    assign accept   = i_valid && o_ready;
    assign cur_idx  = i_sor ? '0 : col_cnt;
    assign complete = accept && (cur_idx >= CNT_BW'(KERNEL_COLS - 1));
    assign w_idx    = int'(i_addr) - BASE_ADDR;
    assign w_hit    = i_w_en && (w_idx >= 0) && (w_idx < TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) weight[k] <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (w_hit && (w_idx == k)) weight[k] <= i_w;
            end
        end
    end

    // col_q[KERNEL_COLS-2] is the newest stored column; i_x completes the window live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < KERNEL_COLS - 1; c++) col_q[c] <= '0;
            col_cnt <= '0;
        end else if (accept) begin
            for (int c = 0; c < KERNEL_COLS - 2; c++) col_q[c] <= col_q[c+1];
            col_q[KERNEL_COLS-2] <= i_x;
            col_cnt <= (cur_idx == CNT_BW'(IMG_WIDTH - 1)) ? '0 : cur_idx + CNT_BW'(1);
        end
    end

    for (genvar r = 0; r < KERNEL_ROWS; r++) begin : g_row
        logic [KERNEL_COLS*DATA_BW-1:0]   rx;
        logic [KERNEL_COLS*WEIGHT_BW-1:0] rw;
        for (genvar c = 0; c < KERNEL_COLS; c++) begin : g_col
            if (c == KERNEL_COLS - 1) begin : g_new
                assign rx[c*DATA_BW +: DATA_BW] = i_x[r*DATA_BW +: DATA_BW];
            end else begin : g_old
                assign rx[c*DATA_BW +: DATA_BW] = col_q[c][r*DATA_BW +: DATA_BW];
            end
            assign rw[c*WEIGHT_BW +: WEIGHT_BW] = weight[r*KERNEL_COLS + c];
        end
        conv_window_row #(
            .KERNEL_COLS (KERNEL_COLS),
            .DATA_BW     (DATA_BW),
            .WEIGHT_BW   (WEIGHT_BW),
            .SUM_BW      (ACC_BW)
        ) u_row (
            .x   (rx),
            .w   (rw),
            .sum (row_sum[r])
        );
    end

    always_comb begin
        acc = ACC_BW'($signed(i_psum));
        for (int r = 0; r < KERNEL_ROWS; r++) acc = acc + row_sum[r];
        acc_ext = 64'(acc);
        if (acc_ext > SAT_HI)      sat = SUM_BW'(SAT_HI);
        else if (acc_ext < SAT_LO) sat = SUM_BW'(SAT_LO);
        else                       sat = SUM_BW'(acc);
`ifdef CONV_WINDOW_RELU_EN
        result = sat[SUM_BW-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_psum  <= '0;
        end else if (complete) begin
            o_valid <= 1'b1;
            o_psum  <= result;
        end else if (i_ready) begin
            o_valid <= 1'b0;
            o_psum  <= '0;
        end
    end

endmodule

// File: tb/tb_conv_window_engine.sv
// tb/tb_conv_window_engine.sv - directed self-checking bench for conv_window_engine
module tb_conv_window_engine;

    localparam int KR = 5;
    localparam int KC = 5;
    localparam int IW = 32;
    localparam int WB = 8;
    localparam int DB = 8;
    localparam int SB = 16;
    localparam int AB = 6;
    localparam int BA = 25;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_w_en = 1'b0;
    logic [AB-1:0] i_addr = '0;
    logic [WB-1:0] i_w = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic          i_sor = 1'b0;
    logic [KR*DB-1:0] i_x = '0;
    logic [SB-1:0] i_psum = '0;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic [SB-1:0] o_psum;

    int n_checks = 0;
    int n_pass = 0;
    int nres;
    longint neg_exp;
    longint shift_exp;

    conv_window_engine #(
        .KERNEL_ROWS (KR), .KERNEL_COLS (KC), .IMG_WIDTH (IW), .WEIGHT_BW (WB),
        .DATA_BW (DB), .SUM_BW (SB), .ADDR_BW (AB), .BASE_ADDR (BA)
    ) dut (
        .clk (clk), .rst_n (rst_n), .i_w_en (i_w_en), .i_addr (i_addr), .i_w (i_w),
        .i_valid (i_valid), .o_ready (o_ready), .i_sor (i_sor), .i_x (i_x),
        .i_psum (i_psum), .o_valid (o_valid), .i_ready (i_ready), .o_psum (o_psum)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input int v);
        for (int k = 0; k < KR*KC; k++) begin
            i_w_en = 1'b1;
            i_addr = AB'(BA + k);
            i_w    = WB'(v);
            tick();
        end
        i_w_en = 1'b0;
    endtask

    task automatic set_col(input int v, input bit sor, input int ps);
        i_valid = 1'b1;
        i_sor   = sor;
        i_psum  = SB'(ps);
        for (int r = 0; r < KR; r++) i_x[r*DB +: DB] = DB'(v);
    endtask

    task automatic col_pulse(input int v, input bit sor, input int ps);
        set_col(v, sor, ps);
        tick();
        i_valid = 1'b0;
        i_sor   = 1'b0;
    endtask

    // Pixel 1 only at row 1 of window column 2, zeros elsewhere.
    task automatic impulse_window(input int ps);
        for (int c = 0; c < KC; c++) begin
            set_col(0, c == 0, ps);
            if (c == 2) i_x[1*DB +: DB] = DB'(1);
            tick();
        end
        i_valid = 1'b0;
        i_sor   = 1'b0;
    endtask

    initial begin
`ifdef CONV_WINDOW_RELU_EN
        neg_exp   = 0;
        shift_exp = 0;
`else
        neg_exp   = -32768;
        shift_exp = -2;
`endif
        tick();
        check_val("rst_valid", o_valid, 0);
        check_val("rst_psum", $signed(o_psum), 0);
        check_val("rst_ready", o_ready, 1);
        rst_n = 1'b1;
        tick();

        load_all(1);
        for (int c = 0; c < KC; c++) begin
            col_pulse(1, c == 0, 0);
            if (c < KC - 1) check_val("ones_fill", o_valid, 0);
        end
        check_val("ones_valid", o_valid, 1);
        check_val("ones_psum", $signed(o_psum), 25);
        tick();
        check_val("ones_drain", o_valid, 0);

        load_all(127);
        for (int c = 0; c < KC; c++) col_pulse(127, c == 0, 0);
        check_val("sat_pos", $signed(o_psum), 32767);
        load_all(-128);
        for (int c = 0; c < KC; c++) col_pulse(127, c == 0, 0);
        check_val("sat_neg_valid", o_valid, 1);
        check_val("sat_neg", $signed(o_psum), neg_exp);

        load_all(1);
        for (int c = 0; c < KC; c++) col_pulse(c + 1, c == 0, 0);
        check_val("bp_first", $signed(o_psum), 75);
        i_ready = 1'b0;
        set_col(6, 0, 0);
        for (int s = 0; s < 3; s++) begin
            #1;
            check_val("bp_ready_low", o_ready, 0);
            tick();
            check_val("bp_hold_valid", o_valid, 1);
            check_val("bp_hold_psum", $signed(o_psum), 75);
        end
        i_ready = 1'b1;
        #1;
        check_val("bp_ready_high", o_ready, 1);
        tick();
        check_val("bp_res2", $signed(o_psum), 100);
        set_col(7, 0, 0);
        tick();
        check_val("bp_res3", $signed(o_psum), 125);
        set_col(8, 0, 0);
        tick();
        check_val("bp_res4", $signed(o_psum), 150);
        i_valid = 1'b0;
        tick();
        check_val("bp_drain", o_valid, 0);

        nres = 0;
        for (int c = 0; c < IW; c++) begin
            col_pulse(1, c == 0, 0);
            nres += int'(o_valid);
        end
        check_val("wrap_count", nres, 28);
        nres = 0;
        for (int c = 0; c < KC - 1; c++) begin
            col_pulse(1, c == 0, 0);
            nres += int'(o_valid);
        end
        check_val("wrap_silent", nres, 0);
        col_pulse(1, 0, 0);
        check_val("wrap_resume", o_valid, 1);
        for (int c = 5; c < 10; c++) col_pulse(1, 0, 0);
        nres = 0;
        for (int c = 0; c < KC - 1; c++) begin
            col_pulse(1, c == 0, 0);
            nres += int'(o_valid);
        end
        check_val("sor_mid_silent", nres, 0);
        col_pulse(1, 0, 0);
        check_val("sor_mid_valid", o_valid, 1);
        check_val("sor_mid_psum", $signed(o_psum), 25);

        load_all(0);
        i_w_en = 1'b1;
        i_addr = AB'(BA + 7);
        i_w    = WB'(3);
        tick();
        i_addr = AB'(BA - 1);
        i_w    = WB'(9);
        tick();
        i_w_en = 1'b0;
        impulse_window(0);
        check_val("decode_impulse", $signed(o_psum), 3);
        impulse_window(-5);
        check_val("decode_psum", $signed(o_psum), shift_exp);
        for (int c = 0; c < KC; c++) col_pulse(1, c == 0, 0);
        check_val("decode_total", $signed(o_psum), 3);

        i_ready = 1'b0;
        for (int c = 0; c < KC; c++) col_pulse(1, c == 0, 0);
        check_val("areset_pre", o_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("areset_valid", o_valid, 0);
        check_val("areset_psum", $signed(o_psum), 0);
        check_val("areset_ready", o_ready, 1);
        #2;
        rst_n   = 1'b1;
        i_ready = 1'b1;
        nres = 0;
        for (int c = 0; c < KC - 1; c++) begin
            col_pulse(1, 0, 0);
            nres += int'(o_valid);
        end
        check_val("areset_fill", nres, 0);
        col_pulse(1, 0, 7);
        check_val("areset_after_valid", o_valid, 1);
        check_val("areset_after_psum", $signed(o_psum), 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
